// File: rtl/cmd_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cmd_pkg
//  Description : Shared constants, FSM state type and parity helper for the
//                command serializer and its upstream stage.
//  Revision    : Rev 1.0 - initial release
// ============================================================================
package cmd_pkg;

    localparam int CMD_WIDTH  = 32;
    localparam int DATA_CNT_W = 6;

    localparam logic [CMD_WIDTH-1:0]  RST_CODE  = 32'hF000_0000;
    localparam logic [DATA_CNT_W-1:0] DATA_LAST = 6'd31;

    localparam logic START_LVL = 1'b0;
    localparam logic STOP_LVL  = 1'b1;
    localparam logic IDLE_LVL  = 1'b1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4,
        GAP    = 3'd5
    } ser_state_e;

    // Bit that makes the ones-count over word plus parity odd.
    function automatic logic odd_parity(input logic [CMD_WIDTH-1:0] word);
        return ~(^word);
    endfunction

endpackage
`default_nettype wire

// File: rtl/cmd_serializer_if.sv
`default_nettype none
// ============================================================================
//  Module      : cmd_serializer_if
//  Description : Command word handshake plus serial line/status bundle.
//  Revision    : Rev 1.0 - initial release
// ============================================================================
interface cmd_serializer_if;
    import cmd_pkg::*;

    logic                 cmd_in_valid;
    logic                 cmd_in_ready;
    logic [CMD_WIDTH-1:0] cmd_in;
    logic                 ser_out;
    logic                 busy;

    modport master (
        output cmd_in_valid,
        output cmd_in,
        input  cmd_in_ready,
        input  ser_out,
        input  busy
    );

    modport slave (
        input  cmd_in_valid,
        input  cmd_in,
        output cmd_in_ready,
        output ser_out,
        output busy
    );

endinterface
`default_nettype wire

// File: rtl/bit_tick_gen.sv
`default_nettype none
// ============================================================================
//  Module      : bit_tick_gen
//  Description : Bit-period divider; pulses tick_o every CLK_DIV cycles and
//                restarts from zero whenever clr_i is high.
//  Revision    : Rev 1.0 - initial release
// ============================================================================
module bit_tick_gen #(
    parameter int unsigned CLK_DIV = 4
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic clr_i,
    output logic      tick_o
);

    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

    logic [7:0] div_cnt_q;
    logic [7:0] div_cnt_d;

    // The tick itself is a bit boundary, so the count wraps on it.
    always_comb begin
        tick_o    = (div_cnt_q == DIV_LAST);
        div_cnt_d = (clr_i || tick_o) ? 8'd0 : div_cnt_q + 8'd1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_cnt_q <= 8'd0;
        end else begin
            div_cnt_q <= div_cnt_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/cmd_serializer.sv
`default_nettype none
// ============================================================================
//  Module      : cmd_serializer
//  Description : Frames a 32-bit command as start/data(MSB first)/[parity]/
//                stop on a single serial line, with an idle gap after each
//                frame. Parity bit present when CMD_SER_PARITY_EN is defined.
//  Revision    : Rev 1.0 - initial release
// ============================================================================
module cmd_serializer
    import cmd_pkg::*;
#(
    parameter int unsigned CLK_DIV  = 4,
    parameter int unsigned GAP_BITS = 2
) (
    input  wire logic       clk,
    input  wire logic       rst,
    cmd_serializer_if.slave bus
);

    localparam logic [3:0] GAP_LAST = (GAP_BITS == 0) ? 4'd0 : 4'(GAP_BITS - 1);

    ser_state_e           state_q;
    ser_state_e           state_d;
    logic [CMD_WIDTH-1:0] word_q;
    logic [CMD_WIDTH-1:0] word_d;
    logic [5:0]           bit_cnt_q;
    logic [5:0]           bit_cnt_d;
    logic [3:0]           gap_cnt_q;
    logic [3:0]           gap_cnt_d;
    logic                 ser_out_q;
    logic                 ser_out_d;
    logic                 busy_q;
    logic                 busy_d;
    logic                 ready_q;
    logic                 ready_d;

    logic                 w_tick;
    logic                 w_xfer;
    logic                 w_div_clr;

    assign w_xfer    = bus.cmd_in_valid && ready_q;
    assign w_div_clr = (state_q == IDLE);

    bit_tick_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_tick (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (w_div_clr),
        .tick_o (w_tick)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            word_q    <= '0;
            bit_cnt_q <= 6'd0;
            gap_cnt_q <= 4'd0;
            ser_out_q <= IDLE_LVL;
            busy_q    <= 1'b0;
            ready_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            word_q    <= word_d;
            bit_cnt_q <= bit_cnt_d;
            gap_cnt_q <= gap_cnt_d;
            ser_out_q <= ser_out_d;
            busy_q    <= busy_d;
            ready_q   <= ready_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        word_d    = word_q;
        bit_cnt_d = bit_cnt_q;
        gap_cnt_d = gap_cnt_q;
        case (state_q)
            IDLE: begin
                if (w_xfer) begin
                    state_d = START;
                    word_d  = bus.cmd_in;
                end
            end
            START: begin
                if (w_tick) begin
                    state_d   = DATA;
                    bit_cnt_d = 6'd0;
                end
            end
            DATA: begin
                if (w_tick) begin
                    // Counter parks at 31 when leaving DATA rather than wrapping.
                    if (bit_cnt_q == DATA_LAST) begin
`ifdef CMD_SER_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end else begin
                        bit_cnt_d = bit_cnt_q + 6'd1;
                    end
                end
            end
            PARITY: begin
                if (w_tick) begin
                    state_d = STOP;
                end
            end
            STOP: begin
                if (w_tick) begin
                    gap_cnt_d = 4'd0;
                    if (GAP_BITS == 0) begin
                        state_d = IDLE;
                    end else begin
                        state_d = GAP;
                    end
                end
            end
            GAP: begin
                if (w_tick) begin
                    if (gap_cnt_q == GAP_LAST) begin
                        state_d = IDLE;
                    end else begin
                        gap_cnt_d = gap_cnt_q + 4'd1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs are decoded from the next state so the registered line leads
    // the state change by no cycle at all.
    always_comb begin
        ready_d = (state_d == IDLE);
        busy_d  = (state_d != IDLE);
        case (state_d)
            START:   ser_out_d = START_LVL;
            DATA:    ser_out_d = word_q[5'd31 - bit_cnt_d[4:0]];
            PARITY:  ser_out_d = odd_parity(word_q);
            STOP:    ser_out_d = STOP_LVL;
            default: ser_out_d = IDLE_LVL;
        endcase
    end

    assign bus.cmd_in_ready = ready_q;
    assign bus.ser_out      = ser_out_q;
    assign bus.busy         = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_cmd_serializer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cmd_serializer
//  Description : Self-checking bench for cmd_serializer (two configurations:
//                CLK_DIV=4/GAP_BITS=2 and CLK_DIV=1/GAP_BITS=0).
//  Revision    : Rev 1.0 - initial release
// ============================================================================
module tb_cmd_serializer;
    import cmd_pkg::*;

    localparam int DIV_A = 4;
    localparam int GAP_A = 2;
    localparam int DIV_B = 1;
    localparam int GAP_B = 0;
`ifdef CMD_SER_PARITY_EN
    localparam int FB = 35;
`else
    localparam int FB = 34;
`endif
    localparam int BUSY_A   = (FB + GAP_A) * DIV_A;
    localparam int PERIOD_A = BUSY_A + 1;
    localparam int PERIOD_B = (FB + GAP_B) * DIV_B + 1;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    cmd_serializer_if bus_a ();
    cmd_serializer_if bus_b ();

    cmd_serializer #(.CLK_DIV(DIV_A), .GAP_BITS(GAP_A)) dut_a (
        .clk (clk), .rst (rst), .bus (bus_a)
    );
    cmd_serializer #(.CLK_DIV(DIV_B), .GAP_BITS(GAP_B)) dut_b (
        .clk (clk), .rst (rst), .bus (bus_b)
    );

    // Line level of frame bit n for word w; past the frame the line idles high.
    function automatic logic model_bit(input logic [31:0] w, input int n);
        if (n == 0) return 1'b0;
        if (n <= 32) return w[5'(32 - n)];
        if (FB == 35 && n == 33) return (($countones(w) % 2) == 0) ? 1'b1 : 1'b0;
        return 1'b1;
    endfunction

    task automatic wait_ready_a(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 1000 && !ok; i++) begin
            @(negedge clk);
            if (bus_a.cmd_in_ready === 1'b1) ok = 1'b1;
        end
    endtask

    task automatic wait_ready_b(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 1000 && !ok; i++) begin
            @(negedge clk);
            if (bus_b.cmd_in_ready === 1'b1) ok = 1'b1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (bus_a.ser_out !== 1'b1 || bus_a.busy !== 1'b0 || bus_a.cmd_in_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_a: ser/busy/ready got %b%b%b want 100",
                     bus_a.ser_out, bus_a.busy, bus_a.cmd_in_ready);
        end
        checks++;
        if (bus_b.ser_out !== 1'b1 || bus_b.busy !== 1'b0 || bus_b.cmd_in_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_b: ser/busy/ready got %b%b%b want 100",
                     bus_b.ser_out, bus_b.busy, bus_b.cmd_in_ready);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (bus_a.cmd_in_ready !== 1'b0) begin
            errors++;
            $display("FAIL ready_before_edge: got %b want 0", bus_a.cmd_in_ready);
        end
        @(negedge clk);
        checks++;
        if (bus_a.cmd_in_ready !== 1'b1 || bus_b.cmd_in_ready !== 1'b1) begin
            errors++;
            $display("FAIL ready_after_release: got a=%b b=%b want 1",
                     bus_a.cmd_in_ready, bus_b.cmd_in_ready);
        end
    endtask

    task automatic test_rst_code_frame();
        logic [31:0] w;
        bit          ok;
        logic        eb;
        w = RST_CODE;
        wait_ready_a(ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL rst_code_ready: timeout got 0 want 1"); end
        bus_a.cmd_in_valid = 1'b1;
        bus_a.cmd_in       = w;
        @(negedge clk);
        bus_a.cmd_in_valid = 1'b0;
        for (int k = 0; k < PERIOD_A; k++) begin
            eb = (k < BUSY_A);
            checks++;
            if (bus_a.ser_out !== model_bit(w, k / DIV_A) || bus_a.busy !== eb ||
                bus_a.cmd_in_ready !== !eb) begin
                errors++;
                $display("FAIL rst_code_cycle%0d: ser/busy/ready got %b%b%b want %b%b%b", k,
                         bus_a.ser_out, bus_a.busy, bus_a.cmd_in_ready,
                         model_bit(w, k / DIV_A), eb, !eb);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_lsb_one();
        logic [31:0] w;
        bit          ok;
        logic        samp [0:399];
        int          busy_cnt;
        bit          done;
        w        = 32'h0000_0001;
        busy_cnt = 0;
        done     = 1'b0;
        for (int i = 0; i < 400; i++) samp[i] = 1'bx;
        wait_ready_a(ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL lsb_ready: timeout got 0 want 1"); end
        bus_a.cmd_in_valid = 1'b1;
        bus_a.cmd_in       = w;
        @(negedge clk);
        bus_a.cmd_in_valid = 1'b0;
        for (int k = 0; k < 400 && !done; k++) begin
            samp[k] = bus_a.ser_out;
            if (bus_a.busy === 1'b1) busy_cnt++;
            else done = 1'b1;
            @(negedge clk);
        end
        checks++;
        if (busy_cnt != BUSY_A) begin
            errors++;
            $display("FAIL lsb_busy_len: got %0d want %0d", busy_cnt, BUSY_A);
        end
        for (int j = 0; j < DIV_A; j++) begin
            checks++;
            if (samp[32 * DIV_A + j] !== 1'b1) begin
                errors++;
                $display("FAIL lsb_last_data%0d: got %b want 1", j, samp[32 * DIV_A + j]);
            end
            checks++;
            if (samp[33 * DIV_A + j] !== model_bit(w, 33)) begin
                errors++;
                $display("FAIL lsb_bit33_%0d: got %b want %b", j, samp[33 * DIV_A + j],
                         model_bit(w, 33));
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] w1;
        logic [31:0] w2;
        bit          ok;
        int          k_rdy;
        int          gap_busy;
        w1       = $urandom;
        w2       = $urandom;
        k_rdy    = -1;
        gap_busy = 0;
        wait_ready_a(ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL b2b_ready: timeout got 0 want 1"); end
        bus_a.cmd_in_valid = 1'b1;
        bus_a.cmd_in       = w1;
        @(negedge clk);
        bus_a.cmd_in = w2;
        for (int k = 0; k < 400 && k_rdy < 0; k++) begin
            if (bus_a.cmd_in_ready === 1'b1) begin
                k_rdy = k;
            end else begin
                checks++;
                if (bus_a.ser_out !== model_bit(w1, k / DIV_A)) begin
                    errors++;
                    $display("FAIL b2b_f1_cycle%0d: got %b want %b", k, bus_a.ser_out,
                             model_bit(w1, k / DIV_A));
                end
                if (k >= FB * DIV_A && bus_a.busy === 1'b1) gap_busy++;
                @(negedge clk);
            end
        end
        checks++;
        if (k_rdy + 1 != PERIOD_A) begin
            errors++;
            $display("FAIL b2b_interval: got %0d want %0d", k_rdy + 1, PERIOD_A);
        end
        checks++;
        if (gap_busy != GAP_A * DIV_A) begin
            errors++;
            $display("FAIL b2b_gap_len: got %0d want %0d", gap_busy, GAP_A * DIV_A);
        end
        @(negedge clk);
        bus_a.cmd_in_valid = 1'b0;
        for (int k = 0; k < FB * DIV_A; k++) begin
            checks++;
            if (bus_a.ser_out !== model_bit(w2, k / DIV_A)) begin
                errors++;
                $display("FAIL b2b_f2_cycle%0d: got %b want %b", k, bus_a.ser_out,
                         model_bit(w2, k / DIV_A));
            end
            @(negedge clk);
        end
    endtask

    task automatic test_random(input int n_frames);
        logic [31:0] w;
        bit          ok;
        logic        eb;
        for (int f = 0; f < n_frames; f++) begin
            w = $urandom;
            wait_ready_a(ok);
            checks++;
            if (!ok) begin errors++; $display("FAIL rand_ready%0d: timeout got 0 want 1", f); end
            repeat ($urandom_range(0, 3)) @(negedge clk);
            bus_a.cmd_in_valid = 1'b1;
            bus_a.cmd_in       = w;
            @(negedge clk);
            for (int k = 0; k < PERIOD_A; k++) begin
                eb = (k < BUSY_A);
                checks++;
                if (bus_a.ser_out !== model_bit(w, k / DIV_A) || bus_a.busy !== eb ||
                    bus_a.cmd_in_ready !== !eb) begin
                    errors++;
                    $display("FAIL rand_f%0d_cycle%0d: ser/busy/ready got %b%b%b want %b%b%b",
                             f, k, bus_a.ser_out, bus_a.busy, bus_a.cmd_in_ready,
                             model_bit(w, k / DIV_A), eb, !eb);
                end
                // Noise on the handshake while the block is not ready.
                bus_a.cmd_in_valid = (k < PERIOD_A - 2) ? 1'($urandom_range(0, 1)) : 1'b0;
                bus_a.cmd_in       = $urandom;
                @(negedge clk);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] w;
        bit          ok;
        int          k_hit;
        w     = $urandom & ~32'h0020_0000;
        k_hit = 11 * DIV_A + 1;
        wait_ready_a(ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL mid_ready: timeout got 0 want 1"); end
        bus_a.cmd_in_valid = 1'b1;
        bus_a.cmd_in       = w;
        @(negedge clk);
        bus_a.cmd_in_valid = 1'b0;
        repeat (k_hit) @(negedge clk);
        checks++;
        if (bus_a.ser_out !== 1'b0 || bus_a.busy !== 1'b1) begin
            errors++;
            $display("FAIL mid_pre_reset: ser/busy got %b%b want 01", bus_a.ser_out, bus_a.busy);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (bus_a.ser_out !== 1'b1 || bus_a.busy !== 1'b0 || bus_a.cmd_in_ready !== 1'b0) begin
            errors++;
            $display("FAIL mid_async: ser/busy/ready got %b%b%b want 100",
                     bus_a.ser_out, bus_a.busy, bus_a.cmd_in_ready);
        end
        @(negedge clk);
        checks++;
        if (bus_a.ser_out !== 1'b1 || bus_a.busy !== 1'b0) begin
            errors++;
            $display("FAIL mid_held: ser/busy got %b%b want 10", bus_a.ser_out, bus_a.busy);
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (bus_a.cmd_in_ready !== 1'b1 || bus_a.ser_out !== 1'b1) begin
            errors++;
            $display("FAIL mid_release: ready/ser got %b%b want 11",
                     bus_a.cmd_in_ready, bus_a.ser_out);
        end
    endtask

    task automatic test_fast();
        logic [31:0] w;
        bit          ok;
        int          kk;
        w = 32'hAAAA_AAAA;
        wait_ready_b(ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL fast_ready: timeout got 0 want 1"); end
        bus_b.cmd_in_valid = 1'b1;
        bus_b.cmd_in       = w;
        @(negedge clk);
        for (int k = 0; k < 2 * PERIOD_B; k++) begin
            kk = k % PERIOD_B;
            checks++;
            if (bus_b.ser_out !== model_bit(w, kk) ||
                bus_b.cmd_in_ready !== ((kk == PERIOD_B - 1) ? 1'b1 : 1'b0)) begin
                errors++;
                $display("FAIL fast_cycle%0d: ser/ready got %b%b want %b%b", k,
                         bus_b.ser_out, bus_b.cmd_in_ready, model_bit(w, kk),
                         (kk == PERIOD_B - 1) ? 1'b1 : 1'b0);
            end
            if (k == 2 * PERIOD_B - 2) bus_b.cmd_in_valid = 1'b0;
            @(negedge clk);
        end
    endtask

    initial begin
        bus_a.cmd_in_valid = 1'b0;
        bus_a.cmd_in       = '0;
        bus_b.cmd_in_valid = 1'b0;
        bus_b.cmd_in       = '0;
        test_reset();
        test_rst_code_frame();
        test_lsb_one();
        test_back_to_back();
        test_random(5);
        test_reset_mid();
        test_random(2);
        test_fast();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: sim time exceeded got timeout want finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
